// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: instruction sequencer driving the accumulator ALU control
// strobes. Accepts one 8-bit instruction per valid/ready handshake, decodes
// it and plays out its control cycles, then pulses done for one cycle.
//
// Optional build macro: ALU_CTRL_ILLEGAL_TRAP_EN
//   defined   - an illegal opcode sets err and parks the FSM in HALT until RST
//   undefined - an illegal opcode sets err and completes as a NOP with done
//
// Ports:
//   Clk          system clock, rising edge
//   RST          synchronous active-high reset
//   instr[7:0]   [7:5] opcode, [4:2] alu_op field, [1:0] bus source index
//   instr_valid  instr offered this cycle
//   instr_ready  sequencer idle and able to accept
//   alu_wen      accumulator write-enable from bus
//   alu_inc      accumulator increment strobe
//   alu_rst      accumulator clear strobe
//   alu_op[2:0]  ALU operation select (000 = none)
//   bus_sel[1:0] bus source select, held between instructions
//   busy         instruction in progress
//   done         one-cycle pulse after the last control cycle
//   err          sticky illegal-opcode flag
module alu_ctrl_seq #(
  parameter int unsigned OP_CYCLES = 1,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic       alu_wen,
  output logic       alu_inc,
  output logic       alu_rst,
  output logic [2:0] alu_op,
  output logic [1:0] bus_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned OPC_W = 3;
  localparam int unsigned AOP_W = 3;
  localparam int unsigned SEL_W = 2;

  localparam logic [OPC_W-1:0] OPC_NOP  = 3'd0;
  localparam logic [OPC_W-1:0] OPC_LOAD = 3'd1;
  localparam logic [OPC_W-1:0] OPC_OP   = 3'd2;
  localparam logic [OPC_W-1:0] OPC_INC  = 3'd3;
  localparam logic [OPC_W-1:0] OPC_CLR  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    ,
    S_HALT = 2'd3
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               wen_q, wen_d;
  logic               inc_q, inc_d;
  logic               rst_q, rst_d;
  logic [AOP_W-1:0]   op_q, op_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  // Instruction decode of the offered word
  logic [OPC_W-1:0]   opcode;
  logic [AOP_W-1:0]   op_field;
  logic [SEL_W-1:0]   src;
  logic [CNT_W-1:0]   dec_len;
  logic               dec_wen, dec_inc, dec_rst, dec_sel_en, dec_illegal;
  logic [AOP_W-1:0]   dec_op;

  assign opcode   = instr[7:5];
  assign op_field = instr[4:2];
  assign src      = instr[1:0];

  // Control length and strobe pattern per opcode
  always_comb begin
    dec_len     = '0;
    dec_wen     = 1'b0;
    dec_inc     = 1'b0;
    dec_rst     = 1'b0;
    dec_op      = '0;
    dec_sel_en  = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_NOP: ;
      OPC_LOAD: begin
        dec_len    = CNT_W'(1);
        dec_wen    = 1'b1;
        dec_sel_en = 1'b1;
      end
      OPC_OP: begin
        // A zero op field is a no-op: no cycles, bus_sel untouched
        if (op_field != '0) begin
          dec_len    = CNT_W'(OP_CYCLES);
          dec_op     = op_field;
          dec_sel_en = 1'b1;
        end
      end
      OPC_INC: begin
        dec_len = CNT_W'(instr[4:0]);
        dec_inc = 1'b1;
      end
      OPC_CLR: begin
        dec_len = CNT_W'(1);
        dec_rst = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    wen_d   = 1'b0;
    inc_d   = 1'b0;
    rst_d   = 1'b0;
    op_d    = '0;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (instr_valid) begin
          ready_d = 1'b0;
          err_d   = err_q | dec_illegal;
          if (dec_illegal) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
            busy_d  = 1'b1;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else if (dec_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // First control cycle is presented from the accept edge
            state_d = S_EXEC;
            busy_d  = 1'b1;
            cnt_d   = dec_len - CNT_W'(1);
            wen_d   = dec_wen;
            inc_d   = dec_inc;
            rst_d   = dec_rst;
            op_d    = dec_op;
            if (dec_sel_en) sel_d = src;
          end
        end
      end
      S_EXEC: begin
        // cnt_q counts control cycles still to follow the current one
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          wen_d  = wen_q;
          inc_d  = inc_q;
          rst_d  = rst_q;
          op_d   = op_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        busy_d = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      inc_q   <= 1'b0;
      rst_q   <= 1'b0;
      op_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      inc_q   <= inc_d;
      rst_q   <= rst_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign alu_wen     = wen_q;
  assign alu_inc     = inc_q;
  assign alu_rst     = rst_q;
  assign alu_op      = op_q;
  assign bus_sel     = sel_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus a random
// instruction stream, checked cycle by cycle against a length/strobe model.
module tb_alu_ctrl_seq;

  localparam int unsigned TB_OP_CYCLES = 3;

  logic       Clk = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready, alu_wen, alu_inc, alu_rst, busy, done, err;
  logic [2:0] alu_op;
  logic [1:0] bus_sel;

  int errors = 0;
  int checks = 0;

  // Model state carried between instructions
  logic [1:0] m_sel = 2'b00;
  logic       m_err = 1'b0;

  logic [10:0] obs;

  alu_ctrl_seq #(.OP_CYCLES(TB_OP_CYCLES), .CNT_W(5)) dut (
    .Clk(Clk), .RST(RST), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_wen(alu_wen), .alu_inc(alu_inc),
    .alu_rst(alu_rst), .alu_op(alu_op), .bus_sel(bus_sel),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  assign obs = {instr_ready, busy, done, err, alu_wen, alu_inc, alu_rst, alu_op, bus_sel};

  function automatic logic [10:0] vec(input logic r, input logic b, input logic d,
                                      input logic e, input logic w, input logic i,
                                      input logic c, input logic [2:0] op,
                                      input logic [1:0] s);
    return {r, b, d, e, w, i, c, op, s};
  endfunction

  // Number of control cycles an instruction word should produce
  function automatic int model_len(input logic [7:0] w);
    case (w[7:5])
      3'd1: return 1;
      3'd2: return (w[4:2] == 3'd0) ? 0 : int'(TB_OP_CYCLES);
      3'd3: return int'(w[4:0]);
      3'd4: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    RST = 1'b1;
    instr_valid = 1'b0;
    @(negedge Clk);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00)) begin
      errors++;
      $display("FAIL reset_values: got %b want %b", obs, vec(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
    end
    RST = 1'b0;
    m_sel = 2'b00;
    m_err = 1'b0;
  endtask

  // Offer one word from IDLE and check every following cycle through DONE.
  // While busy, instr/instr_valid are scrambled (or forced) to show they are ignored.
  task automatic run_instr(input logic [7:0] w, input bit force_busy, input logic [7:0] busy_word);
    int          len;
    logic [2:0]  opc;
    logic [10:0] exp;
    opc = w[7:5];
    len = model_len(w);
    @(negedge Clk);
    exp = vec(1, 0, 0, m_err, 0, 0, 0, 3'b000, m_sel);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL idle_before_%h: got %b want %b", w, obs, exp);
    end
    instr = w;
    instr_valid = 1'b1;
    if (opc >= 3'd5) m_err = 1'b1;
    if (opc == 3'd1 || (opc == 3'd2 && w[4:2] != 3'd0)) m_sel = w[1:0];
    @(posedge Clk);
    #1;
    instr = force_busy ? busy_word : 8'($urandom);
    instr_valid = force_busy ? 1'b1 : 1'($urandom);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    if (opc >= 3'd5) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge Clk);
        exp = vec(0, 1, 0, 1, 0, 0, 0, 3'b000, m_sel);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL halt_%h_c%0d: got %b want %b", w, k, obs, exp);
        end
        instr = 8'b001_000_11;
        instr_valid = 1'b1;
      end
      do_reset();
    end else begin
`else
    begin
`endif
      for (int k = 1; k <= len + 1; k++) begin
        @(negedge Clk);
        if (k <= len)
          exp = vec(0, 1, 0, m_err, opc == 3'd1, opc == 3'd3, opc == 3'd4,
                    (opc == 3'd2) ? w[4:2] : 3'b000, m_sel);
        else
          exp = vec(0, 0, 1, m_err, 0, 0, 0, 3'b000, m_sel);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL exec_%h_c%0d: got %b want %b", w, k, obs, exp);
        end
        if (k == len + 1) begin
          instr_valid = 1'b0;
        end else begin
          instr = force_busy ? busy_word : 8'($urandom);
          instr_valid = force_busy ? 1'b1 : 1'($urandom);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge Clk);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00)) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want %b", obs, vec(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00));
    end
  endtask

  task automatic test_load();
    run_instr(8'b001_000_10, 1'b0, 8'h00);
    run_instr(8'b001_111_01, 1'b0, 8'h00);
  endtask

  task automatic test_inc();
    run_instr(8'b011_00011, 1'b0, 8'h00);
    run_instr(8'b011_00000, 1'b0, 8'h00);
    run_instr(8'b011_00001, 1'b0, 8'h00);
    run_instr(8'b011_11111, 1'b0, 8'h00);
  endtask

  task automatic test_op();
    run_instr(8'b010_011_01, 1'b0, 8'h00);
    run_instr(8'b010_000_11, 1'b0, 8'h00);
    run_instr(8'b010_111_10, 1'b0, 8'h00);
  endtask

  task automatic test_clr_ignore();
    run_instr(8'b100_00000, 1'b1, 8'b001_000_11);
    run_instr(8'b011_00010, 1'b1, 8'b001_000_11);
  endtask

  task automatic test_reset_abort();
    logic [10:0] exp;
    run_instr(8'b001_000_01, 1'b0, 8'h00);
    @(negedge Clk);
    instr = 8'b011_01010;
    instr_valid = 1'b1;
    @(posedge Clk);
    #1;
    instr_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge Clk);
      exp = vec(0, 1, 0, m_err, 0, 1, 0, 3'b000, m_sel);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_inc_c%0d: got %b want %b", k, obs, exp);
      end
    end
    RST = 1'b1;
    m_sel = 2'b00;
    m_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      RST = 1'b0;
      exp = vec(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_after_rst_c%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_illegal();
    run_instr(8'b110_00000, 1'b0, 8'h00);
    run_instr(8'b001_000_11, 1'b0, 8'h00);
    run_instr(8'b111_10101, 1'b0, 8'h00);
    run_instr(8'b100_00000, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    for (int n = 0; n < 60; n++) begin
      w = 8'($urandom);
      // Keep INC counts short so the run stays compact
      if (w[7:5] == 3'd3 && w[4] && (n % 4) != 0) w[4] = 1'b0;
      run_instr(w, 1'b0, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_inc();
    test_op();
    test_clr_ignore();
    test_reset_abort();
    test_illegal();
    test_back_to_back();
    @(negedge Clk);
    checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: got ready=%b busy=%b want ready=1 busy=0", instr_ready, busy);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
